// File: rtl/count_sample_fifo.sv
// -----------------------------------------------------------------------------
// count_sample_fifo
//   First-word-fall-through FIFO that captures counter samples together with
//   their overflow flag and hands them to a back-pressuring consumer over a
//   valid/ready handshake. The counter cannot stall, so samples offered while
//   the FIFO is full are dropped and tallied in a saturating drop counter.
//
//   Optional build macro: COUNT_WRAP_TALLY_EN
//     When defined, adds wrap_cnt, an 8-bit modulo counter of accepted samples
//     whose overflow flag was set.
//
// Ports:
//   clk        in   clock, all logic on rising edge
//   reset      in   synchronous reset, active-low
//   in_valid   in   sample offered this cycle
//   in_data    in   counter sample [DATA_WIDTH]
//   in_ov      in   overflow flag accompanying the sample
//   in_ready   out  FIFO can accept (not full)
//   out_valid  out  head entry available
//   out_data   out  head entry data, 0 when empty
//   out_ov     out  head entry overflow flag, 0 when empty
//   out_ready  in   consumer accepts head this cycle
//   level      out  occupancy 0..DEPTH
//   drop_cnt   out  samples lost to a full FIFO, saturating
//   wrap_cnt   out  (COUNT_WRAP_TALLY_EN only) accepted samples with in_ov=1
// -----------------------------------------------------------------------------
module count_sample_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int DROP_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_ov,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_ov,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  level,
  output logic [DROP_WIDTH-1:0]   drop_cnt
`ifdef COUNT_WRAP_TALLY_EN
  ,
  output logic [7:0]              wrap_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = DATA_WIDTH + 1;

  localparam logic [PW-1:0]         PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [DROP_WIDTH-1:0] DROP_MAX = {DROP_WIDTH{1'b1}};
  localparam logic [DROP_WIDTH-1:0] DROP_ONE = {{(DROP_WIDTH-1){1'b0}}, 1'b1};

  logic [EW-1:0]         mem_r [DEPTH];
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [PW-1:0]         level_r;
  logic [DROP_WIDTH-1:0] drop_cnt_r;
  logic                  full_s;
  logic                  empty_s;
  logic                  push_s;
  logic                  pop_s;
  logic [EW-1:0]         head_s;

  // Occupancy status and handshake qualifiers, all from registered pointers.
  always_comb begin
    // Extra pointer MSB distinguishes full from empty when the low bits match.
    full_s  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
    empty_s = (wr_ptr_r == rd_ptr_r);
    push_s  = in_valid && !full_s;
    pop_s   = out_ready && !empty_s;
  end

  // Pointer, occupancy and drop-counter state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      level_r    <= {PW{1'b0}};
      drop_cnt_r <= {DROP_WIDTH{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + PTR_ONE;
        2'b01:   level_r <= level_r - PTR_ONE;
        default: level_r <= level_r;
      endcase
      // A pop in the same cycle does not rescue a sample offered while full.
      if (in_valid && full_s && (drop_cnt_r != DROP_MAX)) begin
        drop_cnt_r <= drop_cnt_r + DROP_ONE;
      end
    end
  end

  // Sample storage; deliberately not reset, contents are qualified by pointers.
  always_ff @(posedge clk) begin
    if (reset && push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= {in_ov, in_data};
    end
  end

  // Head-of-queue read path, zeroed when nothing is held.
  always_comb begin
    head_s = mem_r[rd_ptr_r[AW-1:0]];
    if (empty_s) begin
      out_data = {DATA_WIDTH{1'b0}};
      out_ov   = 1'b0;
    end else begin
      out_data = head_s[DATA_WIDTH-1:0];
      out_ov   = head_s[DATA_WIDTH];
    end
  end

  // Status outputs come straight from registered state.
  always_comb begin
    in_ready  = !full_s;
    out_valid = !empty_s;
    level     = level_r;
    drop_cnt  = drop_cnt_r;
  end

`ifdef COUNT_WRAP_TALLY_EN
  logic [7:0] wrap_cnt_r;

  // Tally of accepted overflow-tagged samples; dropped samples are not counted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wrap_cnt_r <= 8'd0;
    end else if (push_s && in_ov) begin
      wrap_cnt_r <= wrap_cnt_r + 8'd1;
    end else begin
      wrap_cnt_r <= wrap_cnt_r;
    end
  end

  // Expose the tally.
  always_comb begin
    wrap_cnt = wrap_cnt_r;
  end
`endif

endmodule

// File: tb/tb_count_sample_fifo.sv
// -----------------------------------------------------------------------------
// tb_count_sample_fifo
//   Self-checking bench for count_sample_fifo. Two instances share stimulus:
//   one with the default 8-bit drop counter and one with a 2-bit drop counter
//   to exercise saturation. A queue-based reference model is stepped once per
//   clock edge and compared against both instances on every falling edge;
//   directed sequences add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_count_sample_fifo;

  localparam int DEPTH = 4;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ov;
  logic       out_ready;

  logic       in_ready,   s_in_ready;
  logic       out_valid,  s_out_valid;
  logic [7:0] out_data,   s_out_data;
  logic       out_ov,     s_out_ov;
  logic [2:0] level,      s_level;
  logic [7:0] drop_cnt;
  logic [1:0] s_drop_cnt;
`ifdef COUNT_WRAP_TALLY_EN
  logic [7:0] wrap_cnt,   s_wrap_cnt;
`endif

  count_sample_fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH), .DROP_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ov(in_ov), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ov(out_ov), .out_ready(out_ready),
    .level(level), .drop_cnt(drop_cnt)
`ifdef COUNT_WRAP_TALLY_EN
    , .wrap_cnt(wrap_cnt)
`endif
  );

  count_sample_fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH), .DROP_WIDTH(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ov(in_ov), .in_ready(s_in_ready), .out_valid(s_out_valid),
    .out_data(s_out_data), .out_ov(s_out_ov), .out_ready(out_ready),
    .level(s_level), .drop_cnt(s_drop_cnt)
`ifdef COUNT_WRAP_TALLY_EN
    , .wrap_cnt(s_wrap_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [8:0] q[$];
  int         drop_m;
  int         dsat_m;
  int         wrap_m;
  bit         armed = 1'b0;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs applied at that edge.
  task automatic model_step();
    bit can_push;
    if (!reset) begin
      q.delete();
      drop_m = 0;
      dsat_m = 0;
      wrap_m = 0;
      armed  = 1'b1;
    end else if (armed) begin
      can_push = (q.size() < DEPTH);
      if (in_valid && !can_push) begin
        if (drop_m < 255) drop_m++;
        if (dsat_m < 3)   dsat_m++;
      end
      if (out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && can_push) begin
        q.push_back({in_ov, in_data});
        if (in_ov) wrap_m = (wrap_m + 1) % 256;
      end
    end
  endtask

  // Apply inputs on the falling edge, let one rising edge consume them,
  // step the model, then return just after the edge.
  task automatic cyc(input logic rst, input logic v, input logic [7:0] d,
                     input logic ov, input logic rdy);
    @(negedge clk);
    reset     = rst;
    in_valid  = v;
    in_data   = d;
    in_ov     = ov;
    out_ready = rdy;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (armed) begin
      logic [7:0] ed;
      logic       eo;
      ed = (q.size() > 0) ? q[0][7:0] : 8'd0;
      eo = (q.size() > 0) ? q[0][8]   : 1'b0;
      chk("in_ready",    {31'd0, in_ready},    {31'd0, q.size() < DEPTH});
      chk("out_valid",   {31'd0, out_valid},   {31'd0, q.size() > 0});
      chk("out_data",    {24'd0, out_data},    {24'd0, ed});
      chk("out_ov",      {31'd0, out_ov},      {31'd0, eo});
      chk("level",       {29'd0, level},       q.size());
      chk("drop_cnt",    {24'd0, drop_cnt},    drop_m);
      chk("s_in_ready",  {31'd0, s_in_ready},  {31'd0, q.size() < DEPTH});
      chk("s_out_valid", {31'd0, s_out_valid}, {31'd0, q.size() > 0});
      chk("s_out_data",  {24'd0, s_out_data},  {24'd0, ed});
      chk("s_out_ov",    {31'd0, s_out_ov},    {31'd0, eo});
      chk("s_level",     {29'd0, s_level},     q.size());
      chk("s_drop_cnt",  {30'd0, s_drop_cnt},  dsat_m);
`ifdef COUNT_WRAP_TALLY_EN
      chk("wrap_cnt",    {24'd0, wrap_cnt},    wrap_m);
      chk("s_wrap_cnt",  {24'd0, s_wrap_cnt},  wrap_m);
`endif
    end
  end

  logic [7:0] tag_d [3];
  logic       tag_o [3];

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = 8'd0; in_ov = 1'b0; out_ready = 1'b0;
    tag_d = '{8'hFE, 8'hFF, 8'h00};
    tag_o = '{1'b0, 1'b0, 1'b1};

    // Reset then stream 0..3 with consumer always ready
    cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    chk("rst_level", {29'd0, level}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_drop",  {24'd0, drop_cnt}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, i[7:0], 1'b0, 1'b1);
      chk("stream_valid", {31'd0, out_valid}, 32'd1);
      chk("stream_data",  {24'd0, out_data}, i);
      chk("stream_level", {29'd0, level}, 32'd1);
    end
    cyc(1'b1, 1'b0, 8'd0, 1'b0, 1'b1);
    chk("stream_drained", {29'd0, level}, 32'd0);

    // Fill and drop
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b1, 8'(10 + i), 1'b0, 1'b0);
      if (i == 3) begin
        chk("fill_level", {29'd0, level}, 32'd4);
        chk("fill_ready", {31'd0, in_ready}, 32'd0);
      end
    end
    chk("fill_drop", {24'd0, drop_cnt}, 32'd2);
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", {24'd0, out_data}, 32'(10 + i));
      cyc(1'b1, 1'b0, 8'd0, 1'b0, 1'b1);
    end
    chk("drain_level", {29'd0, level}, 32'd0);

    // Overflow tag alignment
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, tag_d[i], tag_o[i], 1'b0);
`ifdef COUNT_WRAP_TALLY_EN
    chk("tag_wrap", {24'd0, wrap_cnt}, 32'd1);
`endif
    for (int i = 0; i < 3; i++) begin
      chk("tag_data", {24'd0, out_data}, {24'd0, tag_d[i]});
      chk("tag_ov",   {31'd0, out_ov},   {31'd0, tag_o[i]});
      cyc(1'b1, 1'b0, 8'd0, 1'b0, 1'b1);
    end

    // Simultaneous push/pop at level 2, then pop-while-full drops the push
    cyc(1'b1, 1'b1, 8'd20, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'd21, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'd22, 1'b0, 1'b1);
    chk("simul_level", {29'd0, level}, 32'd2);
    chk("simul_head",  {24'd0, out_data}, 32'd21);
    cyc(1'b1, 1'b1, 8'd23, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'd24, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'd25, 1'b0, 1'b1);
    chk("fullpop_level", {29'd0, level}, 32'd3);
    chk("fullpop_drop",  {24'd0, drop_cnt}, 32'd3);
    chk("fullpop_head",  {24'd0, out_data}, 32'd22);

    // Mid-operation reset discards everything
    cyc(1'b0, 1'b1, 8'd99, 1'b1, 1'b1);
    chk("mid_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_level", {29'd0, level}, 32'd0);
    chk("mid_drop",  {24'd0, drop_cnt}, 32'd0);
    chk("mid_data",  {24'd0, out_data}, 32'd0);
    cyc(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
    chk("post_rst_data", {24'd0, out_data}, 32'h55);
    cyc(1'b1, 1'b0, 8'd0, 1'b0, 1'b1);

    // Drop counter saturation on the 2-bit instance
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 8'(40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
    chk("sat_drop2", {30'd0, s_drop_cnt}, 32'd3);
    chk("sat_drop8", {24'd0, drop_cnt}, 32'd6);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'd0, 1'b0, 1'b1);

    // Pointer wrap with 20 push/pop pairs
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b1, i[7:0], 1'b0, 1'b1);
      chk("wrap_order", {24'd0, out_data}, i);
    end
    cyc(1'b1, 1'b0, 8'd0, 1'b0, 1'b1);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) != 0),
          ($urandom_range(0, 3) != 0),
          8'($urandom),
          1'($urandom),
          ($urandom_range(0, 9) < ((i / 500) % 2 == 0 ? 3 : 8)));
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/count_sample_fifo.md
Name: count_sample_fifo

Overview:
- Downstream consumer of the 8-bit counter/bypass path: captures each counter sample and its overflow flag into a small first-word-fall-through FIFO.
- Presents captured samples to a back-pressuring consumer over a valid/ready handshake.
- The counter cannot stall, so samples offered while the FIFO is full are dropped and counted.

Parameters:
DATA_WIDTH, 8, width of sample data (matches counter output)
DEPTH, 4, FIFO entries; power of two, minimum 2
DROP_WIDTH, 8, width of saturating drop counter

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous reset, active-low
in_valid  input  1  sample offered this cycle (tied to counter enable)
in_data  input  DATA_WIDTH  counter sample
in_ov  input  1  overflow flag accompanying sample
in_ready  output  1  FIFO can accept; equals !full
out_valid  output  1  head entry available
out_data  output  DATA_WIDTH  head entry data; 0 when empty
out_ov  output  1  head entry overflow flag; 0 when empty
out_ready  input  1  consumer accepts head this cycle
level  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH
drop_cnt  output  DROP_WIDTH  samples lost to full FIFO, saturating

Behaviour:
- Clock clk; reset is synchronous, active-low, sampled on the rising edge of clk.
- Reset (reset==0 at clk edge): wr_ptr=0, rd_ptr=0, level=0, out_valid=0, drop_cnt=0, wrap_cnt=0 (if built). Storage array is not reset. Reset overrides any push/pop in the same cycle, including mid-stream; all held entries are discarded.
- Push = in_valid && in_ready. Pop = out_valid && out_ready.
- Push writes {in_ov,in_data} at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop advances rd_ptr modulo DEPTH.
- Pointers are clog2(DEPTH)+1 bits; full when the low bits are equal and the MSBs differ; empty when the pointers are equal.
- level: +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency: a push into an empty FIFO gives out_valid=1 on the next cycle, with out_data equal to the pushed value. No same-cycle pass-through.
- out_valid = !empty, registered-state derived. out_data/out_ov read combinationally from storage at rd_ptr, forced to 0 when empty.
- Full: in_ready=0. A pop in the same cycle does not enable a push; in_ready depends only on registered state, with no combinational path from out_ready.
- Empty with out_ready=1: no pop, pointers unchanged.
- Simultaneous push and pop when neither full nor empty: both occur, level unchanged.
- Drop: in_valid && !in_ready increments drop_cnt by 1. It saturates at 2^DROP_WIDTH-1 and stays there until reset.
- Data integrity: entries emerge in push order, with in_ov preserved bit-exact alongside its data.
- Pointer wrap: after DEPTH pushes, wr_ptr low bits return to 0; ordering is preserved across the wrap.

Optional Feature:
COUNT_WRAP_TALLY_EN:
- Defined: adds output port wrap_cnt (8 bits). It increments (mod 256) on every accepted push with in_ov=1, so the consumer can reconstruct the absolute count beyond 8 bits. Dropped samples with in_ov=1 are not counted. Reset value 0.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then stream: reset low 2 cycles, then in_valid=1 with in_data 0,1,2,3 and out_ready=1 -> out_valid rises one cycle after first push; out_data sequence is 0,1,2,3; level never exceeds 1.
- Fill and drop: out_ready=0, push 10,11,12,13,14,15 -> level=4, in_ready=0 after the 4th push; drop_cnt=2; then out_ready=1 drains 10,11,12,13 in order, and level returns to 0.
- Overflow tag: push 0xFE (ov=0), 0xFF (ov=0), 0x00 (ov=1) -> out_ov is 0,0,1 aligned with data; with COUNT_WRAP_TALLY_EN, wrap_cnt=1.
- Simultaneous push/pop at level 2 -> level stays 2 and order holds; when full with out_ready=1 and in_valid=1 -> pop occurs, push dropped, drop_cnt+1, level=3.
- Mid-operation reset: level=3, assert reset one cycle -> next cycle out_valid=0, level=0, drop_cnt=0, out_data=0; the first push afterwards appears as the first output.
- Saturation and wrap: DROP_WIDTH=2, full FIFO, hold in_valid 6 cycles -> drop_cnt=3 and holds. Separately, 20 push/pop pairs -> pointer wrap preserves order 0..19.
